// File: rtl/result_demux.sv
// Routes a byte stream into two independent FIFO channels, A and B, steered either
// directly by Select or alternately by a two-state machine.
module result_demux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         DataIn,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic                     Select,
    input  logic                     Mode,
    output logic [WIDTH-1:0]         NumA,
    output logic                     ValidA,
    input  logic                     ReadyA,
    output logic [WIDTH-1:0]         NumB,
    output logic                     ValidB,
    input  logic                     ReadyB,
    output logic [$clog2(DEPTH):0]   CountA,
    output logic [$clog2(DEPTH):0]   CountB,
    output logic                     dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic { NEXT_A = 1'b0, NEXT_B = 1'b1 } state_t;

    // Handshake: a transfer happens on any edge where valid and ready are both 1;
    // valid never depends on ready, and ready may depend on the current target only.
    state_t                  state;
    logic                    target;
    logic [1:0]              full;
    logic [1:0]              push;
    logic [1:0]              pop;
    logic [1:0]              valid_ch;
    logic [1:0]              ready_ch;
    logic [1:0][WIDTH-1:0]   head;
    logic [1:0][CW-1:0]      count;

    assign target   = Mode ? (state == NEXT_B) : Select;
    assign InReady  = ~full[target];
    assign push[0]  = InValid & InReady & ~target;
    assign push[1]  = InValid & InReady & target;
    assign ready_ch = {ReadyB, ReadyA};
    assign pop      = valid_ch & ready_ch;

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    cnt;

        assign full[ch]     = (cnt == CW'(DEPTH));
        assign valid_ch[ch] = (cnt != '0);
        assign head[ch]     = valid_ch[ch] ? mem[rd_ptr] : '0;
        assign count[ch]    = cnt;

        // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[ch]) begin
                    mem[wr_ptr] <= DataIn;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[ch]) rd_ptr <= rd_ptr + 1'b1;
                case ({push[ch], pop[ch]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Direct mode pins the state to NEXT_A so alternate mode always restarts at A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NEXT_A;
        end else if (!Mode) begin
            state <= NEXT_A;
        end else if (InValid && InReady) begin
            state <= (state == NEXT_A) ? NEXT_B : NEXT_A;
        end
    end

    assign NumA      = head[0];
    assign NumB      = head[1];
    assign ValidA    = valid_ch[0];
    assign ValidB    = valid_ch[1];
    assign CountA    = count[0];
    assign CountB    = count[1];
    assign dbg_state = state;

endmodule

// File: tb/tb_result_demux.sv
// Self-checking bench for result_demux: reference queues per channel, directed
// scenarios for routing, backpressure, alternation, wrap-around and reset.
module tb_result_demux;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] DataIn = '0;
    logic             InValid = 1'b0;
    logic             InReady;
    logic             Select = 1'b0;
    logic             Mode = 1'b0;
    logic [WIDTH-1:0] NumA, NumB;
    logic             ValidA, ValidB;
    logic             ReadyA = 1'b0, ReadyB = 1'b0;
    logic [$clog2(DEPTH):0] CountA, CountB;
    logic             dbg_state;

    result_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .DataIn(DataIn), .InValid(InValid), .InReady(InReady),
        .Select(Select), .Mode(Mode),
        .NumA(NumA), .ValidA(ValidA), .ReadyA(ReadyA),
        .NumB(NumB), .ValidB(ValidB), .ReadyB(ReadyB),
        .CountA(CountA), .CountB(CountB), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_qa[$];
    logic [WIDTH-1:0] exp_qb[$];
    logic [WIDTH-1:0] got_qa[$];
    logic [WIDTH-1:0] got_qb[$];
    logic             m_state = 1'b0;
    logic             m_tgt;
    logic             m_rdy;
    logic             toggle_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, evaluated mid-cycle for the upcoming rising edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_qa.delete();
            exp_qb.delete();
            m_state = 1'b0;
            check("rst_outs", {NumA, NumB, ValidA, ValidB, CountA, CountB}, 0);
        end else begin
            check("count_a", CountA, exp_qa.size());
            check("count_b", CountB, exp_qb.size());
            check("valid_a", ValidA, exp_qa.size() != 0);
            check("valid_b", ValidB, exp_qb.size() != 0);
            if (!ValidA) check("num_a_zero", NumA, 0);
            if (!ValidB) check("num_b_zero", NumB, 0);
            check("state", dbg_state, m_state);
            m_tgt = Mode ? m_state : Select;
            m_rdy = m_tgt ? (exp_qb.size() < DEPTH) : (exp_qa.size() < DEPTH);
            check("in_ready", InReady, m_rdy);
            if (ValidA && ReadyA) begin
                if (exp_qa.size() == 0) check("pop_a_empty", 1, 0);
                else check("pop_a_data", NumA, exp_qa.pop_front());
                got_qa.push_back(NumA);
            end
            if (ValidB && ReadyB) begin
                if (exp_qb.size() == 0) check("pop_b_empty", 1, 0);
                else check("pop_b_data", NumB, exp_qb.pop_front());
                got_qb.push_back(NumB);
            end
            if (InValid && m_rdy) begin
                if (m_tgt) exp_qb.push_back(DataIn);
                else exp_qa.push_back(DataIn);
            end
            if (!Mode) m_state = 1'b0;
            else if (InValid && m_rdy) m_state = ~m_state;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one byte and holds it until accepted, within a cycle budget.
    task automatic send(input logic [WIDTH-1:0] d, input logic sel);
        DataIn  = d;
        Select  = sel;
        InValid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (InReady) begin
                @(posedge clk);
                #1;
                InValid = 1'b0;
                return;
            end
        end
        check("send_timeout", 0, 1);
        InValid = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_num_a", NumA, 0);
        check("rst_cnt_b", CountB, 0);
        idle(2);
        reset = 1'b0;
        check("ready_after_rst", InReady, 1);

        // Direct routing
        Mode = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        check("dir_num_a", NumA, 8'h11);
        check("dir_num_b", NumB, 8'h22);
        check("dir_cnt_a", CountA, 1);
        check("dir_cnt_b", CountB, 1);
        ReadyA = 1'b1; ReadyB = 1'b1;
        idle(2);
        ReadyA = 1'b0; ReadyB = 1'b0;

        // Full channel backpressure
        got_qa.delete();
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        DataIn = 8'hA2; InValid = 1'b1;
        idle(2);
        check("bp_cnt_full", CountA, 2);
        check("bp_not_ready", InReady, 0);
        ReadyA = 1'b1;
        idle(1);
        ReadyA = 1'b0;
        check("bp_cnt_after_pop", CountA, 1);
        send(8'hA2, 1'b0);
        ReadyA = 1'b1;
        idle(4);
        ReadyA = 1'b0;
        check("bp_order_n", got_qa.size(), 3);
        check("bp_order_0", got_qa[0], 8'hA0);
        check("bp_order_1", got_qa[1], 8'hA1);
        check("bp_order_2", got_qa[2], 8'hA2);

        // Alternate mode
        got_qa.delete(); got_qb.delete();
        ReadyA = 1'b1; ReadyB = 1'b1;
        Mode = 1'b1;
        for (int i = 1; i <= 4; i++) send(WIDTH'(i), 1'b1);
        idle(3);
        check("alt_a_n", got_qa.size(), 2);
        check("alt_a_0", got_qa[0], 8'h01);
        check("alt_a_1", got_qa[1], 8'h03);
        check("alt_b_n", got_qb.size(), 2);
        check("alt_b_0", got_qb[0], 8'h02);
        check("alt_b_1", got_qb[1], 8'h04);
        send(8'h44, 1'b0);
        Mode = 1'b0;
        idle(1);
        Mode = 1'b1;
        ReadyA = 1'b0; ReadyB = 1'b0;
        send(8'h33, 1'b1);
        check("alt_restart_valid_a", ValidA, 1);
        check("alt_restart_num_a", NumA, 8'h33);
        check("alt_restart_valid_b", ValidB, 0);
        ReadyA = 1'b1;
        idle(2);

        // Alternate stall on a full A channel
        Mode = 1'b0;
        idle(1);
        Mode = 1'b1;
        ReadyA = 1'b0; ReadyB = 1'b1;
        send(8'hB0, 1'b0);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        DataIn = 8'hB4; InValid = 1'b1;
        idle(2);
        check("stall_not_ready", InReady, 0);
        check("stall_b_empty", ValidB, 0);
        check("stall_cnt_a", CountA, 2);
        ReadyA = 1'b1;
        idle(1);
        ReadyA = 1'b0;
        check("stall_state_a", dbg_state, 0);
        send(8'hB4, 1'b0);
        check("stall_state_b", dbg_state, 1);
        send(8'hB5, 1'b0);
        check("stall_next_b_valid", ValidB, 1);
        check("stall_next_b_num", NumB, 8'hB5);
        ReadyA = 1'b1;
        idle(4);

        // Wrap-around with a toggling consumer
        Mode = 1'b0;
        ReadyA = 1'b0; ReadyB = 1'b0;
        got_qa.delete();
        toggle_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(WIDTH'(i), 1'b0);
                toggle_done = 1'b1;
            end
            begin
                while (!toggle_done) begin
                    @(posedge clk);
                    #1;
                    ReadyA = ~ReadyA;
                    if (CountA > 2) check("wrap_cnt_le2", CountA, 2);
                end
            end
        join
        ReadyA = 1'b1;
        idle(4);
        check("wrap_n", got_qa.size(), 8);
        for (int i = 0; i < 8; i++) check("wrap_data", got_qa[i], i);

        // Reset mid-operation
        ReadyA = 1'b0; ReadyB = 1'b0;
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mrst_outs", {NumA, NumB, ValidA, ValidB, CountA, CountB}, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_ready", InReady, 1);
        Mode = 1'b1;
        send(8'h5A, 1'b1);
        check("mrst_valid_a", ValidA, 1);
        check("mrst_num_a", NumA, 8'h5A);
        check("mrst_valid_b", ValidB, 0);
        ReadyA = 1'b1;
        idle(3);
        check("final_cnt_a", CountA, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_demux.md
RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 Parameter WIDTH, default 8, sets the data byte width of DataIn, NumA and NumB.
REQ-002 Parameter DEPTH, default 2, sets entries per output channel buffer; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 DataIn  input  WIDTH  byte offered for routing.
REQ-006 InValid  input  1  DataIn is valid this cycle.
REQ-007 InReady  output  1  block accepts DataIn this cycle.
REQ-008 Select  input  1  target in direct mode: 0 = channel A, 1 = channel B.
REQ-009 Mode  input  1  0 = direct (Select steers), 1 = alternate (A, B, A, B ...).
REQ-010 NumA  output  WIDTH  channel A head byte.
REQ-011 ValidA  output  1  NumA holds valid data.
REQ-012 ReadyA  input  1  channel A consumer takes NumA.
REQ-013 NumB, ValidB, ReadyB  same as NumA, ValidA, ReadyA for channel B.
REQ-014 CountA, CountB  output  clog2(DEPTH)+1  occupancy of each channel buffer.

Function
REQ-015 An input transfer SHALL occur on a cycle with InValid=1 and InReady=1.
REQ-016 Target channel SHALL be Select when Mode=0, and the alternate-state channel when Mode=1.
REQ-017 InReady SHALL be 1 exactly when the target channel buffer is not full (Count < DEPTH), evaluated combinationally from the current Mode, Select and state.
REQ-018 A full channel SHALL NOT accept a push, even when it pops in the same cycle.
REQ-019 Each channel SHALL be a FIFO. Bytes leave in acceptance order with no loss or duplication.
REQ-020 Latency: a byte pushed into an empty channel SHALL appear on NumX with ValidX=1 on the next cycle.
REQ-021 ValidX SHALL equal (CountX != 0). NumX SHALL be the oldest stored byte when ValidX=1, and all zeros when ValidX=0.
REQ-022 A pop SHALL occur on a cycle with ValidX=1 and ReadyX=1. ReadyX with ValidX=0 SHALL have no effect.
REQ-023 Simultaneous push and pop on a non-full, non-empty channel SHALL leave CountX unchanged and advance the head.
REQ-024 Simultaneous push and pop on an empty channel is impossible (ValidX=0). The push alone SHALL apply.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH. CountX SHALL saturate at neither bound (it is bounded by REQ-017/REQ-022).
REQ-026 The alternate state machine SHALL have two states: NEXT_A (target A) and NEXT_B (target B).
REQ-027 With Mode=1, an accepted transfer in NEXT_A SHALL move to NEXT_B, and in NEXT_B SHALL move to NEXT_A. With no transfer, the state SHALL hold.
REQ-028 With Mode=0, the state SHALL be forced to NEXT_A on every clock, so entering Mode=1 always starts at A.
REQ-029 In Mode=1, a full target channel SHALL stall input (InReady=0) and SHALL NOT skip to the other channel.
REQ-030 Channels A and B SHALL pop independently; a stall on one SHALL NOT block pops on the other.

Reset
REQ-031 On reset=1, the block SHALL asynchronously clear both buffers, pointers and counts, and SHALL set state to NEXT_A.
REQ-032 During reset, outputs SHALL be NumA=NumB=0, ValidA=ValidB=0, CountA=CountB=0. InReady SHALL be 1 once reset deasserts (both channels empty).
REQ-033 Reset asserted mid-operation SHALL discard all buffered bytes. No pop SHALL be signalled afterward for pre-reset data.

Verification
REQ-034 Direct routing: Mode=0; push 0x11 with Select=0, then 0x22 with Select=1; ReadyA=ReadyB=0 -> next cycles NumA=0x11, NumB=0x22, CountA=CountB=1.
REQ-035 Full/backpressure: Mode=0, Select=0, ReadyA=0; push 0xA0, 0xA1, then hold 0xA2 valid -> CountA=2, InReady=0, 0xA2 not accepted. Raise ReadyA one cycle -> pops 0xA0; 0xA2 is accepted only on a following cycle; output order is 0xA0, 0xA1, 0xA2.
REQ-036 Alternate mode: Mode=1; push 0x01, 0x02, 0x03, 0x04 back-to-back with consumers ready -> A receives 0x01, 0x03 and B receives 0x02, 0x04. Toggling Mode to 0 and back to 1 -> next byte goes to A.
REQ-037 Alternate stall: Mode=1, ReadyA=0, A full, state NEXT_A -> InReady=0 and B receives nothing. Pop A -> transfer proceeds to A, then state moves to NEXT_B.
REQ-038 Wrap-around: DEPTH=2; stream 8 bytes 0x00..0x07 through channel A with ReadyA toggling every cycle -> exact in-order output, CountA never exceeds 2.
REQ-039 Reset mid-operation: with CountA=2 and CountB=1, pulse reset asynchronously between clock edges -> outputs immediately go to zeros/ValidX=0. After release, a first push of 0x5A in Mode=1 goes to A.
